fifo1_rr_arbiter: RTL and testbench
===================================

# fifo1_rr_arbiter

Round-robin arbiter that shares one single-element buffer stage among NUM_IN producers. It grants at most one producer per cycle and captures that producer's word and source index into a one-deep register stage, then presents it to a single consumer. It sits where several request sources converge on one downstream pipe, and has the same one-element, one-transfer-per-two-cycles semantics as the existing one-deep FIFO stage.

## Interface
- WIDTH, 32: data word width in bits.
- NUM_IN, 4: number of producers; legal range 2..16.
- IDW, $clog2(NUM_IN): source-index width (derived, not overridden).
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset. Synchronous, active-high.
- in_req  in  NUM_IN  per-producer intent to enqueue. Must not depend combinationally on in_enq__RDY.
- in_enq__ENA  in  NUM_IN  enqueue strobe. Legal only when the matching in_enq__RDY bit is 1.
- in_enq_v  in  NUM_IN*WIDTH  producer data; producer i occupies bits [i*WIDTH +: WIDTH].
- in_last  in  NUM_IN  end-of-burst flag per producer. Ignored unless lock is compiled in.
- in_enq__RDY  out  NUM_IN  one-hot or zero grant.
- out_deq__ENA  in  1  consumer dequeue. Legal only when out_deq__RDY is 1.
- out_deq__RDY  out  1  the buffer is full.
- out_first  out  WIDTH  buffered word.
- out_first__RDY  out  1  equal to out_deq__RDY.
- out_src  out  IDW  index of the producer that wrote the buffered word.

## Operation
- State:
  - element[WIDTH]
  - src[IDW]
  - full
  - ptr[IDW], the round-robin start point
  - lock and lock_id, present only with the macro
- Grant when !full:
  - g is the first index i with in_req[i]=1, scanning ptr, ptr+1, … and wrapping modulo NUM_IN.
  - in_enq__RDY is one-hot at g; it is all-zero if no requests.
  - in_enq__RDY is all-zero whenever full=1.
- Enqueue (!full and in_enq__ENA[g]):
  - element ← in_enq_v slice g.
  - src ← g.
  - full ← 1.
  - ptr ← (g+1) mod NUM_IN. Wrap from NUM_IN-1 to 0; this is not a power-of-two wrap.
- Dequeue (full and out_deq__ENA): full ← 0. element and src hold their values.
- Enqueue and dequeue never coincide, because RDY requires !full. Peak throughput is one word every 2 cycles.
- If a request is withdrawn without ENA, ptr is unchanged.
- ENA on an ungranted bit is a protocol violation and is ignored; the bench flags it with an assertion.

## Timing
- Grant is combinational from in_req, ptr and full in the same cycle. There is no added latency.
- The data is visible on out_first the cycle after the enqueue edge.
- The earliest re-grant is the cycle after the dequeue edge.
- Reset values:
  - full=0, element=0, src=0, ptr=0, lock=0, lock_id=0.
  - Hence out_deq__RDY=0, out_first__RDY=0, out_first=0, out_src=0.
  - in_enq__RDY follows in_req with ptr=0.
- RST asserted mid-operation discards any buffered word on that edge. A coincident ENA or deq is ignored.

## Configuration
- Macro: FIFO1_RR_ARBITER_LOCK_EN.
- With the macro defined:
  - An enqueue with in_last[g]=0 sets lock=1 and lock_id=g.
  - While lock=1, only lock_id can be granted. This holds even if other producers request and lock_id does not.
  - An enqueue from lock_id with in_last=1 clears lock.
  - ptr still advances on every enqueue.
- Without the macro: in_last is unused, and there is no lock state or logic.
- Port lists are identical in both builds.

## Structure
- Package fifo1_arb_pkg holds:
  - the NUM_IN limit constant (16);
  - the function computing IDW, which returns a minimum of 1;
  - a typedef for the source index.
- Sub-module fifo1_rr_pick is a combinational rotating priority picker:
  - inputs: req[NUM_IN], ptr[IDW];
  - outputs: gnt one-hot, gnt_idx, any.
- The top level holds all registers and the lock logic.

## Test plan
- Reset, then in_req=0: every output is 0 except in_enq__RDY=0. Hold RST=1 with in_req=4'b1111: in_enq__RDY=4'b0001 and no state change.
- NUM_IN=4, all four request continuously and always ENA when granted, with an immediate dequeue every time: out_src sequence is 0,1,2,3,0 and one word every 2 cycles.
- Fill from producer 2 with v=32'hA5A5_0002, then hold the dequeue off 5 cycles: in_enq__RDY=0 and out_first is stable at 32'hA5A5_0002 throughout. Then deq: RDY returns the next cycle.
- ptr=3, requests only on 1 and 3: producer 3 is granted, then ptr wraps to 0 and producer 1 is granted.
- Lock build: producer 1 sends last=0, 0, 1 while producer 0 requests throughout. out_src is 1,1,1 then 0.
- RST pulsed while full with out_deq__ENA=1: next cycle full=0, out_first=0, ptr=0.

Source files
------------

// File: rtl/fifo1_arb_pkg.sv
// ============================================================================
//  Module      : fifo1_arb_pkg
//  Description : Shared constants, types and helpers for the one-deep
//                round-robin arbiter (fifo1_rr_arbiter) and its picker.
//  Contents    : MAX_NUM_IN - largest supported producer count
//                idw_calc   - source-index width, never below 1 bit
//                src_idx_t  - source index wide enough for MAX_NUM_IN
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo1_arb_pkg;

    localparam int MAX_NUM_IN = 16;
    localparam int MAX_IDW    = $clog2(MAX_NUM_IN);

    // Width of a producer index. A two-producer arbiter still needs one bit.
    function automatic int idw_calc(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

    typedef logic [MAX_IDW-1:0] src_idx_t;

endpackage

`default_nettype wire

// File: rtl/fifo1_rr_pick.sv
// ============================================================================
//  Module      : fifo1_rr_pick
//  Description : Combinational rotating-priority picker. Returns the first
//                requester found scanning i_ptr, i_ptr+1, ... modulo NUM_IN.
//  Ports       : i_req     [NUM_IN] request vector
//                i_ptr     [IDW]    scan start index (must be < NUM_IN)
//                o_gnt     [NUM_IN] one-hot grant, zero when no request
//                o_gnt_idx [IDW]    index of the granted requester
//                o_any              at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo1_rr_pick
    import fifo1_arb_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int IDW    = idw_calc(NUM_IN)
) (
    input  logic [NUM_IN-1:0] i_req,
    input  logic [IDW-1:0]    i_ptr,
    output logic [NUM_IN-1:0] o_gnt,
    output logic [IDW-1:0]    o_gnt_idx,
    output logic              o_any
);

    logic [IDW-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest requester to
    // i_ptr is the last one written and therefore wins.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        w_idx     = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            w_idx = IDW'((int'(i_ptr) + k) % NUM_IN);
            if (i_req[w_idx]) begin
                o_gnt        = '0;
                o_gnt[w_idx] = 1'b1;
                o_gnt_idx    = w_idx;
                o_any        = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo1_rr_arbiter.sv
// ============================================================================
//  Module      : fifo1_rr_arbiter
//  Description : Round-robin arbiter feeding a single one-deep buffer stage.
//                At most one producer is granted per cycle while the buffer is
//                empty; the granted word and its source index are captured and
//                held until the consumer dequeues.
//  Ports       : CLK, RST (sync, active-high)
//                in_req/in_enq__ENA/in_last [NUM_IN], in_enq_v [NUM_IN*WIDTH]
//                in_enq__RDY [NUM_IN] one-hot grant
//                out_deq__ENA, out_deq__RDY, out_first [WIDTH],
//                out_first__RDY, out_src [IDW]
//  Options     : FIFO1_RR_ARBITER_LOCK_EN - burst lock; an enqueue with
//                in_last=0 pins the grant to that producer until it enqueues
//                with in_last=1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo1_rr_arbiter
    import fifo1_arb_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int IDW    = idw_calc(NUM_IN)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_IN-1:0]       in_req,
    input  logic [NUM_IN-1:0]       in_enq__ENA,
    input  logic [NUM_IN*WIDTH-1:0] in_enq_v,
    input  logic [NUM_IN-1:0]       in_last,
    output logic [NUM_IN-1:0]       in_enq__RDY,
    input  logic                    out_deq__ENA,
    output logic                    out_deq__RDY,
    output logic [WIDTH-1:0]        out_first,
    output logic                    out_first__RDY,
    output logic [IDW-1:0]          out_src
);

    logic [WIDTH-1:0]  r_element;
    logic [IDW-1:0]    r_src;
    logic              r_full;
    logic [IDW-1:0]    r_ptr;

    logic [NUM_IN-1:0] w_req_eff;
    logic [NUM_IN-1:0] w_gnt;
    logic [IDW-1:0]    w_gnt_idx;
    logic              w_any;
    logic              w_enq;
    logic              w_deq;
    logic [WIDTH-1:0]  w_enq_data;
    src_idx_t          w_next_wide;
    logic [IDW-1:0]    w_ptr_next;

`ifdef FIFO1_RR_ARBITER_LOCK_EN
    logic              r_lock;
    logic [IDW-1:0]    r_lock_id;

    // While locked only the owner may be granted, even if it is idle.
    assign w_req_eff = r_lock ? (in_req & (NUM_IN'(1) << r_lock_id)) : in_req;
`else
    logic              w_unused_last;

    assign w_req_eff     = in_req;
    assign w_unused_last = ^in_last;
`endif

    fifo1_rr_pick #(
        .NUM_IN (NUM_IN),
        .IDW    (IDW)
    ) u_pick (
        .i_req     (w_req_eff),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    assign in_enq__RDY = r_full ? '0 : w_gnt;
    assign w_enq       = !r_full && w_any && in_enq__ENA[w_gnt_idx];
    assign w_deq       = r_full && out_deq__ENA;
    assign w_enq_data  = in_enq_v[w_gnt_idx*WIDTH +: WIDTH];

    // Wrap at NUM_IN, which need not be a power of two.
    assign w_next_wide = src_idx_t'(w_gnt_idx) + src_idx_t'(1);
    assign w_ptr_next  = (w_next_wide == src_idx_t'(NUM_IN)) ? '0 : IDW'(w_next_wide);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_element <= '0;
            r_src     <= '0;
            r_full    <= 1'b0;
            r_ptr     <= '0;
        end else if (w_enq) begin
            r_element <= w_enq_data;
            r_src     <= w_gnt_idx;
            r_full    <= 1'b1;
            r_ptr     <= w_ptr_next;
        end else if (w_deq) begin
            r_full    <= 1'b0;
        end
    end

`ifdef FIFO1_RR_ARBITER_LOCK_EN
    // The grant is restricted to the owner while locked, so every locked
    // enqueue comes from r_lock_id and its in_last decides the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lock    <= 1'b0;
            r_lock_id <= '0;
        end else if (w_enq) begin
            r_lock    <= ~in_last[w_gnt_idx];
            r_lock_id <= w_gnt_idx;
        end
    end
`endif

    assign out_deq__RDY   = r_full;
    assign out_first__RDY = r_full;
    assign out_first      = r_element;
    assign out_src        = r_src;

endmodule

`default_nettype wire

// File: tb/tb_fifo1_rr_arbiter.sv
`default_nettype none

module tb_fifo1_rr_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic [N-1:0]   in_req = '0;
    logic [N-1:0]   in_enq__ENA;
    logic [N*W-1:0] in_enq_v;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_enq__RDY;
    logic           out_deq__ENA;
    logic           out_deq__RDY;
    logic [W-1:0]   out_first;
    logic           out_first__RDY;
    logic [1:0]     out_src;

    bit           auto_ena = 1'b0;
    bit           auto_deq = 1'b0;
    logic [N-1:0] man_ena  = '0;
    bit           man_deq  = 1'b0;
    bit           lock_test = 1'b0;
    bit           chk_en   = 1'b0;
    int           p1_cnt   = 0;

    int n_vec = 0;
    int n_err = 0;

    fifo1_rr_arbiter #(.WIDTH(W), .NUM_IN(N)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .in_req         (in_req),
        .in_enq__ENA    (in_enq__ENA),
        .in_enq_v       (in_enq_v),
        .in_last        (in_last),
        .in_enq__RDY    (in_enq__RDY),
        .out_deq__ENA   (out_deq__ENA),
        .out_deq__RDY   (out_deq__RDY),
        .out_first      (out_first),
        .out_first__RDY (out_first__RDY),
        .out_src        (out_src)
    );

    always #5 CLK = ~CLK;

    initial in_enq_v = {32'hD0D0_0003, 32'hA5A5_0002, 32'hC1C1_0001, 32'hB0B0_0000};

    // Producers and consumer react to the grant/ready in the same cycle.
    always_comb begin
        in_enq__ENA  = auto_ena ? (in_enq__RDY & in_req) : man_ena;
        out_deq__ENA = auto_deq ? out_deq__RDY : man_deq;
        in_last      = lock_test ? {2'b11, (p1_cnt == 2), 1'b1} : 4'b1111;
    end

    always @(posedge CLK) begin
        if (RST) p1_cnt <= 0;
        else if (in_enq__ENA[1] && in_enq__RDY[1]) p1_cnt <= p1_cnt + 1;
    end

    // ---------------- behavioural model ----------------
    bit         m_full = 1'b0;
    logic [W-1:0] m_elem = '0;
    int         m_src = 0;
    int         m_ptr = 0;
    bit         m_lock = 1'b0;
    int         m_lock_id = 0;
    int         cur_g;
    logic [N-1:0] exp_rdy;

    function automatic int model_grant(input logic [N-1:0] req, input int ptr,
                                       input bit lock, input int lock_id);
        for (int k = 0; k < N; k++) begin
            int i = (ptr + k) % N;
            if (req[i] && (!lock || i == lock_id)) return i;
        end
        return -1;
    endfunction

    always_comb begin
        cur_g   = model_grant(in_req, m_ptr, m_lock, m_lock_id);
        exp_rdy = '0;
        if (!m_full && cur_g >= 0) exp_rdy = 4'(1 << cur_g);
    end

    always @(posedge CLK) begin
        if (RST) begin
            m_full <= 1'b0; m_elem <= '0; m_src <= 0; m_ptr <= 0;
            m_lock <= 1'b0; m_lock_id <= 0;
        end else if (!m_full) begin
            if (cur_g >= 0 && in_enq__ENA[cur_g]) begin
                m_full <= 1'b1;
                m_elem <= in_enq_v[cur_g*W +: W];
                m_src  <= cur_g;
                m_ptr  <= (cur_g + 1) % N;
`ifdef FIFO1_RR_ARBITER_LOCK_EN
                if (!in_last[cur_g]) begin
                    m_lock <= 1'b1; m_lock_id <= cur_g;
                end else if (m_lock && cur_g == m_lock_id) begin
                    m_lock <= 1'b0;
                end
`endif
            end
        end else if (out_deq__ENA) begin
            m_full <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("model_rdy",       64'(in_enq__RDY),    64'(exp_rdy));
            check("model_deq_rdy",   64'(out_deq__RDY),   64'(m_full));
            check("model_first_rdy", 64'(out_first__RDY), 64'(m_full));
            check("model_first",     64'(out_first),      64'(m_elem));
            check("model_src",       64'(out_src),        64'(m_src));
            if (!RST) begin
                assert ((in_enq__ENA & ~in_enq__RDY) == '0)
                    else $error("enqueue strobe on an ungranted producer");
                assert (!(out_deq__ENA && !out_deq__RDY))
                    else $error("dequeue strobe while buffer empty");
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; tick(); tick(); RST = 1'b0;
    endtask

    // Collect the source index of each dequeue and the cycle it happened on.
    task automatic collect(input int want, output int srcs[8], output int cycs[8], output int got);
        got = 0;
        for (int c = 0; c < 40 && got < want; c++) begin
            @(negedge CLK);
            if (out_deq__RDY) begin
                srcs[got] = int'(out_src);
                cycs[got] = c;
                got++;
            end
        end
    endtask

    initial begin
        int srcs[8];
        int cycs[8];
        int got;
        int exp_lock[4];

        // Reset state with no requests.
        tick();
        chk_en = 1'b1;
        @(negedge CLK);
        check("rst_rdy",       64'(in_enq__RDY),    64'h0);
        check("rst_deq_rdy",   64'(out_deq__RDY),   64'h0);
        check("rst_first_rdy", 64'(out_first__RDY), 64'h0);
        check("rst_first",     64'(out_first),      64'h0);
        check("rst_src",       64'(out_src),        64'h0);
        // Requests under reset are granted from ptr=0; an ENA is ignored.
        @(posedge CLK); #1;
        in_req  = 4'b1111;
        man_ena = 4'b0001;
        @(negedge CLK);
        check("rst_req_rdy", 64'(in_enq__RDY), 64'h1);
        tick();
        man_ena = '0;
        @(negedge CLK);
        check("rst_no_fill", 64'(out_deq__RDY), 64'h0);
        check("rst_req_rdy2", 64'(in_enq__RDY), 64'h1);
        @(posedge CLK); #1;
        RST = 1'b0; in_req = '0;
        tick();

        // All four request continuously; immediate dequeue.
        in_req = 4'b1111; auto_ena = 1'b1; auto_deq = 1'b1;
        collect(5, srcs, cycs, got);
        check("rr_count", 64'(got), 64'd5);
        for (int i = 0; i < 5 && i < got; i++) begin
            check("rr_src", 64'(srcs[i]), 64'(i % 4));
            if (i > 0) check("rr_spacing", 64'(cycs[i] - cycs[i-1]), 64'd2);
        end
        @(posedge CLK); #1;
        in_req = '0; auto_ena = 1'b0;
        tick(); tick();

        // Fill from producer 2 and hold the dequeue off.
        do_reset();
        in_req = 4'b0100; auto_ena = 1'b1; auto_deq = 1'b0;
        tick();
        in_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("hold_rdy",   64'(in_enq__RDY), 64'h0);
            check("hold_first", 64'(out_first),   64'hA5A5_0002);
            check("hold_src",   64'(out_src),     64'd2);
        end
        // Dequeue; ptr is 3 and only producers 1 and 3 now request.
        @(posedge CLK); #1;
        man_deq = 1'b1; in_req = 4'b1010;
        tick();
        man_deq = 1'b0;
        @(negedge CLK);
        check("wrap_rdy3", 64'(in_enq__RDY), 64'b1000);
        tick();
        auto_deq = 1'b1;
        @(negedge CLK);
        check("wrap_src3",   64'(out_src),   64'd3);
        check("wrap_first3", 64'(out_first), 64'hD0D0_0003);
        tick();
        @(negedge CLK);
        check("wrap_rdy1", 64'(in_enq__RDY), 64'b0010);
        @(posedge CLK); #1;
        in_req = '0; auto_ena = 1'b0;
        tick(); tick();

        // Burst lock: producer 1 sends last=0,0,1 while producer 0 waits.
        do_reset();
        lock_test = 1'b1;
        in_req = 4'b0010; auto_ena = 1'b1; auto_deq = 1'b1;
        tick();
        in_req = 4'b0011;
`ifdef FIFO1_RR_ARBITER_LOCK_EN
        exp_lock = '{1, 1, 1, 0};
`else
        exp_lock = '{1, 0, 1, 0};
`endif
        collect(4, srcs, cycs, got);
        check("lock_count", 64'(got), 64'd4);
        for (int i = 0; i < 4 && i < got; i++)
            check("lock_src", 64'(srcs[i]), 64'(exp_lock[i]));
        @(posedge CLK); #1;
        in_req = '0; auto_ena = 1'b0; lock_test = 1'b0;
        tick(); tick();

        // Reset while full with a coincident dequeue.
        do_reset();
        in_req = 4'b0010; auto_ena = 1'b1; auto_deq = 1'b0;
        tick();
        auto_ena = 1'b0; in_req = 4'b1111; man_deq = 1'b1; RST = 1'b1;
        tick();
        RST = 1'b0; man_deq = 1'b0;
        @(negedge CLK);
        check("rstmid_full",  64'(out_deq__RDY), 64'h0);
        check("rstmid_first", 64'(out_first),    64'h0);
        check("rstmid_src",   64'(out_src),      64'h0);
        check("rstmid_ptr0",  64'(in_enq__RDY),  64'b0001);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
